// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Brief    : Per-channel button synchroniser, tick-qualified debouncer and
//            press/release/long-press/toggle decoder.
// Revision : 1.0
// ============================================================================
module btn_conditioner #(
    parameter int CHANNELS = 5,
    parameter int DEBOUNCE = 4,
    parameter int LONG     = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_tick,
    input  logic [CHANNELS-1:0] i_btn_in,
    output logic [CHANNELS-1:0] o_level,
    output logic [CHANNELS-1:0] o_press,
    output logic [CHANNELS-1:0] o_release,
    output logic [CHANNELS-1:0] o_long_press,
    output logic [CHANNELS-1:0] o_toggle
);

    localparam int              C_DW    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int              C_HW    = $clog2(LONG + 1);
    localparam logic [C_DW-1:0] C_DLAST = C_DW'(DEBOUNCE - 1);
    localparam logic [C_HW-1:0] C_HMAX  = C_HW'(LONG);
    localparam logic [C_HW-1:0] C_HFIRE = C_HW'(LONG - 1);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic            r_s1_q, r_s2_q, r_level_q, r_press_q, r_release_q;
        logic            r_long_press_q, r_toggle_q;
        logic            w_s1_d, w_s2_d, w_level_d, w_press_d, w_release_d;
        logic            w_long_press_d, w_toggle_d;
        logic [C_DW-1:0] r_dcnt_q, w_dcnt_d;
        logic [C_HW-1:0] r_hcnt_q, w_hcnt_d;

        always_comb begin
            w_s1_d         = i_btn_in[g];
            w_s2_d         = r_s1_q;
            w_level_d      = r_level_q;
            w_dcnt_d       = r_dcnt_q;
            w_hcnt_d       = r_hcnt_q;
            w_press_d      = 1'b0;
            w_release_d    = 1'b0;
            w_long_press_d = 1'b0;

            if (i_tick) begin
                if (r_s2_q != r_level_q) begin
                    if (r_dcnt_q == C_DLAST) begin
                        w_level_d   = r_s2_q;
                        w_dcnt_d    = '0;
                        w_press_d   = r_s2_q;
                        w_release_d = ~r_s2_q;
                    end else begin
                        w_dcnt_d = r_dcnt_q + C_DW'(1);
                    end
                end else begin
                    w_dcnt_d = '0;
                end
            end

            // A press edge always has level low, so this clear also covers it
            if (!r_level_q) begin
                w_hcnt_d = '0;
            end else if (i_tick && (r_hcnt_q != C_HMAX)) begin
                w_hcnt_d       = r_hcnt_q + C_HW'(1);
                w_long_press_d = (r_hcnt_q == C_HFIRE);
            end

            w_toggle_d = r_toggle_q ^ w_press_d;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_s1_q         <= 1'b0;
                r_s2_q         <= 1'b0;
                r_level_q      <= 1'b0;
                r_dcnt_q       <= '0;
                r_hcnt_q       <= '0;
                r_press_q      <= 1'b0;
                r_release_q    <= 1'b0;
                r_long_press_q <= 1'b0;
                r_toggle_q     <= 1'b0;
            end else begin
                r_s1_q         <= w_s1_d;
                r_s2_q         <= w_s2_d;
                r_level_q      <= w_level_d;
                r_dcnt_q       <= w_dcnt_d;
                r_hcnt_q       <= w_hcnt_d;
                r_press_q      <= w_press_d;
                r_release_q    <= w_release_d;
                r_long_press_q <= w_long_press_d;
                r_toggle_q     <= w_toggle_d;
            end
        end

        assign o_level[g]      = r_level_q;
        assign o_press[g]      = r_press_q;
        assign o_release[g]    = r_release_q;
        assign o_long_press[g] = r_long_press_q;
        assign o_toggle[g]     = r_toggle_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_conditioner
// Brief    : Scoreboard bench for btn_conditioner with a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_btn_conditioner;
    localparam int CH = 4;
    localparam int DB = 4;
    localparam int LG = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tick;
    logic [CH-1:0] btn;
    logic [CH-1:0] o_level, o_press, o_release, o_long_press, o_toggle;

    btn_conditioner #(.CHANNELS(CH), .DEBOUNCE(DB), .LONG(LG)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_tick       (tick),
        .i_btn_in     (btn),
        .o_level      (o_level),
        .o_press      (o_press),
        .o_release    (o_release),
        .o_long_press (o_long_press),
        .o_toggle     (o_toggle)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] lvl;
        logic [CH-1:0] prs;
        logic [CH-1:0] rel;
        logic [CH-1:0] lp;
        logic [CH-1:0] tog;
    } exp_t;

    exp_t          q[$];
    int            total = 0;
    int            bad   = 0;

    // Model: synchronised samples, accepted level, length of the current
    // disagreement run in ticks, and ticks spent high since the press.
    logic [CH-1:0] m_s1, m_s2, m_lvl, m_tog;
    int            m_run[CH];
    int            m_held[CH];

    task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic t, input logic [CH-1:0] b);
        exp_t e;
        logic was_high;
        rst_n = r;
        tick  = t;
        btn   = b;
        e     = '0;
        if (!r) begin
            m_s1  = '0;
            m_s2  = '0;
            m_lvl = '0;
            m_tog = '0;
            for (int c = 0; c < CH; c++) begin
                m_run[c]  = 0;
                m_held[c] = 0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                was_high = m_lvl[c];
                if (t) begin
                    if (m_s2[c] != m_lvl[c]) begin
                        m_run[c]++;
                        if (m_run[c] == DB) begin
                            m_lvl[c] = m_s2[c];
                            m_run[c] = 0;
                            if (m_s2[c]) e.prs[c] = 1'b1;
                            else         e.rel[c] = 1'b1;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end
                if (!was_high) begin
                    m_held[c] = 0;
                end else if (t && m_held[c] < LG) begin
                    m_held[c]++;
                    if (m_held[c] == LG) e.lp[c] = 1'b1;
                end
                if (e.prs[c]) m_tog[c] = ~m_tog[c];
            end
            m_s2 = m_s1;
            m_s1 = b;
        end
        e.lvl = m_lvl;
        e.tog = m_tog;
        q.push_back(e);
        @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("level",      o_level,      e.lvl);
            check("press",      o_press,      e.prs);
            check("release",    o_release,    e.rel);
            check("long_press", o_long_press, e.lp);
            check("toggle",     o_toggle,     e.tog);
        end
    end

    initial begin
        logic [CH-1:0] b;
        int            flip_div;
        int            tick_div;
        rst_n = 1'b0;
        tick  = 1'b0;
        btn   = '0;

        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        check("rst_level", o_level, '0);
        check("rst_press", o_press, '0);
        check("rst_toggle", o_toggle, '0);

        // Single press on channel 0, held through the following scenarios
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b1, 4'b0001);
            if (k == 6) begin
                check("t1_level0", CH'(o_level[0]), CH'(1));
                check("t1_press0", CH'(o_press[0]), CH'(1));
                check("t1_toggle0", CH'(o_toggle[0]), CH'(1));
            end
            if (k == 7)  check("t1_press0_off", CH'(o_press[0]), CH'(0));
            if (k == 13) check("t1_long0_early", CH'(o_long_press[0]), CH'(0));
            if (k == 14) check("t1_long0", CH'(o_long_press[0]), CH'(1));
            if (k == 15) check("t1_long0_off", CH'(o_long_press[0]), CH'(0));
        end

        // Bounce on channel 1: high 3, low 1, high 2, low
        for (int k = 0; k < 16; k++) begin
            b = 4'b0001;
            if (k < 3 || k == 4 || k == 5) b[1] = 1'b1;
            step(1'b1, 1'b1, b);
        end
        check("t2_level1", CH'(o_level[1]), CH'(0));
        check("t2_toggle1", CH'(o_toggle[1]), CH'(0));

        // Sparse tick on channel 2
        for (int k = 0; k < 40; k++) step(1'b1, (k % 4) == 3, 4'b0101);
        check("t3_level2", CH'(o_level[2]), CH'(1));

        // Short press on channel 3, then a second press
        for (int k = 0; k < 11; k++) step(1'b1, 1'b1, 4'b1101);
        for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 4'b0101);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 4'b1101);
        check("t4_toggle3", CH'(o_toggle[3]), CH'(0));

        // All channels together, then reset while held
        for (int k = 0; k < 12; k++) step(1'b1, 1'b1, 4'b0000);
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 1'b1, 4'b1111);
            if (k == 6) check("t5_press_all", o_press, 4'b1111);
        end
        step(1'b0, 1'b1, 4'b1111);
        check("t5_rst_level", o_level, '0);
        check("t5_rst_toggle", o_toggle, '0);
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b1, 4'b1111);
            if (k == 6) check("t5_press_again", o_press, 4'b1111);
        end

        // Randomised segments with varying bounce rate and tick density
        b = 4'b1111;
        for (int s = 0; s < 30; s++) begin
            flip_div = ($urandom_range(0, 1) == 0) ? 3 : 40;
            tick_div = $urandom_range(1, 3);
            for (int k = 0; k < 100; k++) begin
                for (int c = 0; c < CH; c++)
                    if ($urandom_range(0, flip_div - 1) == 0) b[c] = ~b[c];
                step(($urandom_range(0, 499) != 0), ($urandom_range(0, tick_div - 1) == 0), b);
            end
        end

        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, '0);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
